// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed scan driver for an 8-digit common-anode
//               seven-segment display. Each digit slot starts with a guard
//               interval where every anode is off. At the end of that interval
//               the returned character is sampled, hex-decoded and its anode
//               is lit for the rest of the slot.
// Ports       : clk            - system clock
//               reset          - asynchronous active-high reset
//               enable         - scan enable; low forces the display dark
//               one_char       - character code for the current slot
//               refreshcounter - current slot index (registered)
//               anode          - digit enables, active-low (registered)
//               seg            - segments {g,f,e,d,c,b,a}, active-low (registered)
//               dp             - decimal point, active-low, always off
//               frame_tick     - one-cycle pulse when the slot index wraps to 0
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int DIV_COUNT    = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int NUM_DIGITS   = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] one_char,
    output logic [2:0] refreshcounter,
    output logic [7:0] anode,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int               CNT_W      = $clog2(DIV_COUNT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV_COUNT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]       SLOT_LAST  = 3'(NUM_DIGITS - 1);
    localparam logic [7:0]       ANODE_OFF  = 8'hFF;
    localparam logic [6:0]       SEG_OFF    = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       slot_nxt;
    logic [7:0]       anode_nxt;
    logic [6:0]       seg_nxt;
    logic             tick_nxt;

    // Hex character to active-low segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            refreshcounter <= 3'd0;
            anode          <= ANODE_OFF;
            seg            <= SEG_OFF;
            frame_tick     <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            refreshcounter <= slot_nxt;
            anode          <= anode_nxt;
            seg            <= seg_nxt;
            frame_tick     <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        slot_nxt  = refreshcounter;
        anode_nxt = anode;
        seg_nxt   = seg;
        tick_nxt  = 1'b0;

        if (!enable) begin
            // Abandon the current slot; scanning restarts from slot 0
            state_nxt = IDLE;
            cnt_nxt   = '0;
            slot_nxt  = 3'd0;
            anode_nxt = ANODE_OFF;
            seg_nxt   = SEG_OFF;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    slot_nxt  = 3'd0;
                    anode_nxt = ANODE_OFF;
                    seg_nxt   = SEG_OFF;
                end
                BLANK: begin
                    cnt_nxt   = cnt + 1'b1;
                    anode_nxt = ANODE_OFF;
                    seg_nxt   = SEG_OFF;
                    if (cnt == BLANK_LAST) begin
                        // Single sample point of one_char for this slot
                        state_nxt = SHOW;
                        seg_nxt   = hex_to_seg(one_char);
                        anode_nxt = ~(8'b1 << refreshcounter);
                    end
                end
                SHOW: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        // New slot index becomes valid on the same edge that
                        // darkens the display, giving the mux the guard time
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                        anode_nxt = ANODE_OFF;
                        seg_nxt   = SEG_OFF;
                        if (refreshcounter == SLOT_LAST) begin
                            slot_nxt = 3'd0;
                            tick_nxt = 1'b1;
                        end else begin
                            slot_nxt = refreshcounter + 3'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    slot_nxt  = 3'd0;
                    anode_nxt = ANODE_OFF;
                    seg_nxt   = SEG_OFF;
                end
            endcase
        end
    end

    assign dp = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Directed self-checking bench for seg7_scan_driver with
//               DIV_COUNT=8, BLANK_CYCLES=2, NUM_DIGITS=7.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int NDIG  = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] one_char;
    logic [2:0] refreshcounter;
    logic [7:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    // Character mux model: slot index + 1, or an override value
    logic       use_ovr;
    logic [3:0] ovr_val;
    assign one_char = use_ovr ? ovr_val : ({1'b0, refreshcounter} + 4'd1);

    int n_checks = 0;
    int n_fail   = 0;

    // Position model: slot s, in-slot count c
    int s;
    int c;

    logic [6:0] seg_tab [16];

    seg7_scan_driver #(
        .DIV_COUNT   (DIV),
        .BLANK_CYCLES(BLANK),
        .NUM_DIGITS  (NDIG)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .one_char      (one_char),
        .refreshcounter(refreshcounter),
        .anode         (anode),
        .seg           (seg),
        .dp            (dp),
        .frame_tick    (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_pos();
        c++;
        if (c == DIV) begin
            c = 0;
            s = (s + 1) % NDIG;
        end
    endtask

    task automatic advance(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            step_pos();
        end
    endtask

    initial begin
        int ticks;
        int t_first;
        int t_second;
        int a7_low;
        logic [7:0] exp_an;
        logic [6:0] exp_sg;

        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        use_ovr = 1'b0;
        ovr_val = 4'h0;
        reset   = 1'b1;
        enable  = 1'b1;

        // Reset held 3 cycles with enable high
        repeat (3) tick();
        check_eq("rst_anode", anode, 8'hFF);
        check_eq("rst_seg", seg, 7'h7F);
        check_eq("rst_rc", refreshcounter, 3'd0);
        check_eq("rst_tick", frame_tick, 1'b0);
        check_eq("rst_dp", dp, 1'b1);
        reset = 1'b0;

        // First lit anode 3 edges after the first enabled edge
        tick();
        check_eq("lat_e1", anode, 8'hFF);
        tick();
        check_eq("lat_e2", anode, 8'hFF);
        tick();
        check_eq("lat_e3_anode", anode, 8'hFE);
        check_eq("lat_e3_seg", seg, 7'h79);
        s = 0;
        c = BLANK;

        // Two full frames, every cycle checked against the position model
        ticks = 0; t_first = -1; t_second = -1; a7_low = 0;
        for (int i = 1; i <= 2 * NDIG * DIV; i++) begin
            tick();
            step_pos();
            if (c >= BLANK) begin
                exp_an = ~(8'b1 << s);
                exp_sg = seg_tab[s + 1];
            end else begin
                exp_an = 8'hFF;
                exp_sg = 7'h7F;
            end
            check_eq("scan_anode", anode, exp_an);
            check_eq("scan_seg", seg, exp_sg);
            check_eq("scan_rc", refreshcounter, s[2:0]);
            check_eq("scan_tick", frame_tick, (s == 0 && c == 0) ? 1'b1 : 1'b0);
            if (frame_tick) begin
                ticks++;
                if (t_first < 0) t_first = i;
                else if (t_second < 0) t_second = i;
            end
            if (!anode[7]) a7_low++;
        end
        check_eq("wrap_count", ticks, 2);
        check_eq("wrap_spacing", t_second - t_first, 56);
        check_eq("anode7_never_low", a7_low, 0);

        // Sample point: 8 sampled, then changed to F mid-slot
        use_ovr = 1'b1;
        ovr_val = 4'h8;
        advance(NDIG * DIV);
        check_eq("samp_anode", anode, 8'hFE);
        check_eq("samp_seg_c2", seg, 7'h00);
        advance(2);
        ovr_val = 4'hF;
        for (int k = 0; k < 4; k++) begin
            check_eq("samp_seg_hold", seg, 7'h00);
            advance(1);
        end
        // now at slot 1, c=0; move to next slot 0 lit point
        advance((NDIG - 1) * DIV + BLANK);
        check_eq("samp_next_anode", anode, 8'hFE);
        check_eq("samp_next_seg", seg, 7'h0E);

        // Enable drop mid-SHOW in slot 3
        use_ovr = 1'b0;
        advance(3 * DIV + 2);
        check_eq("en_pre_anode", anode, 8'hF7);
        check_eq("en_pre_rc", refreshcounter, 3'd3);
        check_eq("en_pre_seg", seg, 7'h19);
        enable = 1'b0;
        tick();
        check_eq("en_drop_anode", anode, 8'hFF);
        check_eq("en_drop_rc", refreshcounter, 3'd0);
        check_eq("en_drop_seg", seg, 7'h7F);
        tick();
        check_eq("en_idle_anode", anode, 8'hFF);
        enable = 1'b1;
        tick();
        check_eq("re_e1", anode, 8'hFF);
        tick();
        check_eq("re_e2", anode, 8'hFF);
        tick();
        check_eq("re_e3_anode", anode, 8'hFE);
        check_eq("re_e3_seg", seg, 7'h79);
        check_eq("re_e3_rc", refreshcounter, 3'd0);

        // Async reset between edges during SHOW of slot 1
        tick(); tick(); tick(); tick(); tick(); tick();
        tick(); tick();
        check_eq("ar_pre_anode", anode, 8'hFD);
        #2;
        reset = 1'b1;
        #1;
        check_eq("ar_anode", anode, 8'hFF);
        check_eq("ar_seg", seg, 7'h7F);
        check_eq("ar_rc", refreshcounter, 3'd0);
        check_eq("ar_tick", frame_tick, 1'b0);
        #1;
        reset = 1'b0;
        tick();
        check_eq("ar_after_e1", anode, 8'hFF);
        tick();
        tick();
        check_eq("ar_after_lit", anode, 8'hFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
